// File: rtl/uart_csr_pkg.sv
// Shared constants and types for the UART APB control/status slave.
// Register offsets, CTRL bit positions, FSM state encoding and byte-lane merge helper.
package uart_csr_pkg;

  localparam logic [7:0] OFF_DATA     = 8'h00;
  localparam logic [7:0] OFF_BAUD     = 8'h04;
  localparam logic [7:0] OFF_CTRL     = 8'h08;
  localparam logic [7:0] OFF_INT_EN   = 8'h0C;
  localparam logic [7:0] OFF_INT_STAT = 8'h10;
  localparam logic [7:0] OFF_THR      = 8'h14;
  localparam logic [7:0] OFF_STATUS   = 8'h18;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PAR_EN   = 1;
  localparam int CTRL_PAR_ODD  = 2;
  localparam int CTRL_BLOCK    = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_STALL, ST_DONE} csr_state_e;

  typedef struct packed {
    logic        wr;
    logic [7:0]  off;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } csr_req_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = strb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/uart_int_ctrl.sv
// Interrupt status: rising-edge capture of raw sources into sticky W1C bits,
// and a registered irq from the enabled pending bits.
module uart_int_ctrl #(
  parameter int NUM_INT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] int_src,
  input  logic [NUM_INT-1:0] int_en,
  input  logic [NUM_INT-1:0] clr,
  output logic [NUM_INT-1:0] stat,
  output logic               irq
);

  logic [NUM_INT-1:0] src_q;
  logic [NUM_INT-1:0] rise;

  assign rise = int_src & ~src_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      stat  <= '0;
      irq   <= 1'b0;
    end else begin
      src_q <= int_src;
      // a new edge in the same cycle as a clear keeps the bit set
      stat  <= (stat & ~clr) | rise;
      irq   <= |(stat & int_en);
    end
  end

endmodule

// File: rtl/apb_uart_csr.sv
// APB3 control/status slave for the UART: register file, FIFO push/pop strobes,
// wait-state backpressure with timeout, and error responses.
module apb_uart_csr
  import uart_csr_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          BAUD_W    = 16,
  parameter int          BAUD_RST  = 977,
  parameter int          THR_W     = 4,
  parameter int          NUM_INT   = 5,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
  parameter int          TIMEOUT   = 16,
  parameter int          PRIV_ONLY = 0
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  input  logic [3:0]         pstrb,
  input  logic [2:0]         pprot,
  output logic               pready,
  output logic               pslverr,
  output logic [31:0]        prdata,
  input  logic               tx_full,
  input  logic               rx_empty,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic [THR_W-1:0]   rx_level,
  input  logic [THR_W-1:0]   tx_level,
  input  logic [NUM_INT-1:0] int_src,
  output logic               tx_push,
  output logic [DATA_W-1:0]  tx_data,
  output logic               rx_pop,
  output logic [BAUD_W-1:0]  baud_div,
  output logic               uart_en,
  output logic               parity_en,
  output logic               parity_odd,
  output logic [THR_W-1:0]   tx_thr_val,
  output logic [THR_W-1:0]   rx_thr_val,
  output logic               irq
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  csr_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  csr_req_t           req;
  logic               acc_err, is_data, blocked;
  logic               done_ok, wr_ok, rd_ok;
  logic [BAUD_W-1:0]  baud_q;
  logic [3:0]         ctrl_q;
  logic [NUM_INT-1:0] int_en_q, int_stat, w1c;
  logic [2*THR_W-1:0] thr_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic [31:0]        m_baud, m_ctrl, m_en, m_thr, m_clr, rd_val;
  logic               unused_prot;

  assign unused_prot = &{1'b0, pprot[2:1]};

  assign req = '{wr: pwrite, off: paddr[7:0], wdata: pwdata, strb: pstrb};

  assign is_data = (req.off == OFF_DATA);
  assign blocked = is_data && (req.wr ? tx_full : rx_empty);
  assign acc_err = (paddr[1:0] != 2'b00)
                || (paddr[31:8] != BASE_ADDR[31:8])
                || (req.off > OFF_STATUS)
                || (req.wr && req.off == OFF_STATUS)
                || (req.wr && req.strb == 4'h0)
                || ((PRIV_ONLY != 0) && !pprot[0]);

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (psel && !penable) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!(psel && penable)) state_d = ST_IDLE;
        else if (acc_err) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (blocked && ctrl_q[CTRL_BLOCK]) state_d = ST_STALL;
        else begin
          // non-blocking mode turns a full/empty FIFO into an error
          state_d = ST_DONE;
          err_d   = blocked;
        end
      end
      ST_STALL: begin
        if (!psel) state_d = ST_IDLE;
        else if (!blocked) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // side effects only when the master still holds psel in the completing cycle
  assign done_ok = (state_q == ST_DONE) && !err_q && psel;
  assign wr_ok   = done_ok && req.wr;
  assign rd_ok   = done_ok && !req.wr;

  assign pready  = (state_q == ST_DONE);
  assign pslverr = (state_q == ST_DONE) && err_q;
  assign tx_push = wr_ok && is_data;
  assign rx_pop  = rd_ok && is_data;

  always_comb begin
    m_baud = strb_merge(32'(baud_q), req.wdata, req.strb);
    m_ctrl = strb_merge(32'(ctrl_q), req.wdata, req.strb);
    m_en   = strb_merge(32'(int_en_q), req.wdata, req.strb);
    m_thr  = strb_merge(32'(thr_q), req.wdata, req.strb);
    m_clr  = strb_merge(32'h0, req.wdata, req.strb);
  end

  assign w1c = (wr_ok && req.off == OFF_INT_STAT) ? m_clr[NUM_INT-1:0] : '0;

  always_ff @(posedge pclk) begin
    if (preset) begin
      baud_q    <= BAUD_W'(BAUD_RST);
      ctrl_q    <= '0;
      int_en_q  <= '0;
      thr_q     <= '0;
      tx_data_q <= '0;
    end else begin
      if (state_q == ST_ACCESS && psel && req.wr && is_data)
        tx_data_q <= req.wdata[DATA_W-1:0];
      if (wr_ok) begin
        case (req.off)
          OFF_BAUD:   baud_q   <= m_baud[BAUD_W-1:0];
          OFF_CTRL:   ctrl_q   <= m_ctrl[3:0];
          OFF_INT_EN: int_en_q <= m_en[NUM_INT-1:0];
          OFF_THR:    thr_q    <= m_thr[2*THR_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (req.off)
      OFF_DATA:     rd_val[DATA_W-1:0]    = rx_data;
      OFF_BAUD:     rd_val[BAUD_W-1:0]    = baud_q;
      OFF_CTRL:     rd_val[3:0]           = ctrl_q;
      OFF_INT_EN:   rd_val[NUM_INT-1:0]   = int_en_q;
      OFF_INT_STAT: rd_val[NUM_INT-1:0]   = int_stat;
      OFF_THR:      rd_val[2*THR_W-1:0]   = thr_q;
      OFF_STATUS:   rd_val[2*THR_W+1:0]   = {tx_level, rx_level, tx_full, rx_empty};
      default: ;
    endcase
  end

  assign prdata = rd_ok ? rd_val : '0;

  uart_int_ctrl #(.NUM_INT(NUM_INT)) u_int (
    .clk     (pclk),
    .rst     (preset),
    .int_src (int_src),
    .int_en  (int_en_q),
    .clr     (w1c),
    .stat    (int_stat),
    .irq     (irq)
  );

  assign baud_div   = baud_q;
  assign uart_en    = ctrl_q[CTRL_EN];
  assign parity_en  = ctrl_q[CTRL_PAR_EN];
  assign parity_odd = ctrl_q[CTRL_PAR_ODD];
  assign tx_thr_val = thr_q[THR_W-1:0];
  assign rx_thr_val = thr_q[2*THR_W-1:THR_W];
  assign tx_data    = tx_data_q;

endmodule

// File: tb/tb_apb_uart_csr.sv
// Scoreboard bench for apb_uart_csr: each transfer queues its expected response,
// the APB driver queues what the slave returned, and each test drains and compares.
module tb_apb_uart_csr;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic        tx_full, rx_empty;
  logic [7:0]  rx_data;
  logic [3:0]  rx_level, tx_level;
  logic [4:0]  int_src;
  logic        tx_push, rx_pop;
  logic [7:0]  tx_data;
  logic [15:0] baud_div;
  logic        uart_en, parity_en, parity_odd;
  logic [3:0]  tx_thr_val, rx_thr_val;
  logic        irq;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  waits;
  } rsp_t;

  rsp_t  exp_q[$];
  rsp_t  obs_q[$];
  string nm_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_push = 0;
  int    n_pop = 0;
  logic [7:0] last_txd = '0;

  localparam int TIMEOUT = 16;

  always #5 pclk = ~pclk;

  apb_uart_csr #(.PRIV_ONLY(1)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .tx_full(tx_full), .rx_empty(rx_empty), .rx_data(rx_data),
    .rx_level(rx_level), .tx_level(tx_level), .int_src(int_src),
    .tx_push(tx_push), .tx_data(tx_data), .rx_pop(rx_pop), .baud_div(baud_div),
    .uart_en(uart_en), .parity_en(parity_en), .parity_odd(parity_odd),
    .tx_thr_val(tx_thr_val), .rx_thr_val(rx_thr_val), .irq(irq)
  );

  always @(negedge pclk) begin
    if (tx_push) begin
      n_push++;
      last_txd = tx_data;
    end
    if (rx_pop) n_pop++;
  end

  // waits = access-phase cycles with pready low
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, input logic [2:0] prot);
    int   w;
    rsp_t o;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wd; pstrb = strb; pprot = prot;
    @(negedge pclk);
    penable = 1'b1;
    w = 0;
    while (!pready && w < 64) begin
      w++;
      @(negedge pclk);
    end
    o.rdata = wr ? 32'h0 : prdata;
    o.err   = pslverr;
    o.waits = 8'(w);
    obs_q.push_back(o);
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic xfer(input string nm, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] erd, input logic eerr, input int ew);
    rsp_t e;
    e.rdata = wr ? 32'h0 : erd;
    e.err   = eerr;
    e.waits = 8'(ew);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    apb(wr, addr, wd, strb, prot);
  endtask

  task automatic test_reset;
    rsp_t e, o;
    string nm;
    n_vec++;
    if ({pready, pslverr, tx_push, rx_pop, irq} !== 5'b0 || prdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b err=%b push=%b pop=%b irq=%b rdata=%h, want all 0",
               pready, pslverr, tx_push, rx_pop, irq, prdata);
    end
    n_vec++;
    if (baud_div !== 16'd977 || {uart_en, parity_en, parity_odd} !== 3'b0) begin
      n_err++;
      $display("FAIL reset_regs: got baud=%0d ctrl=%b, want baud=977 ctrl=000",
               baud_div, {uart_en, parity_en, parity_odd});
    end
    xfer("rst_baud",   0, 32'h104, 0, 4'hF, 3'b001, 32'd977, 0, 1);
    xfer("rst_ctrl",   0, 32'h108, 0, 4'hF, 3'b001, 32'd0,   0, 1);
    xfer("rst_int_en", 0, 32'h10C, 0, 4'hF, 3'b001, 32'd0,   0, 1);
    xfer("rst_thr",    0, 32'h114, 0, 4'hF, 3'b001, 32'd0,   0, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got rdata=%h err=%b waits=%0d, want rdata=%h err=%b waits=%0d",
                 nm, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_regs;
    rsp_t e, o;
    string nm;
    xfer("baud_wr", 1, 32'h104, 32'h0010, 4'hF, 3'b001, 0, 0, 1);
    xfer("baud_rd", 0, 32'h104, 0, 4'hF, 3'b001, 32'h0010, 0, 1);
    n_vec++;
    if (baud_div !== 16'd16) begin
      n_err++;
      $display("FAIL baud_div: got %0d want 16", baud_div);
    end
    xfer("ctrl_wr", 1, 32'h108, 32'h7, 4'hF, 3'b001, 0, 0, 1);
    n_vec++;
    if ({uart_en, parity_en, parity_odd} !== 3'b111) begin
      n_err++;
      $display("FAIL ctrl_pins: got %b want 111", {uart_en, parity_en, parity_odd});
    end
    // only lane 0 written: upper byte keeps its old 0x00
    xfer("baud_strb_wr", 1, 32'h104, 32'hABCD, 4'b0001, 3'b001, 0, 0, 1);
    xfer("baud_strb_rd", 0, 32'h104, 0, 4'hF, 3'b001, 32'h00CD, 0, 1);
    xfer("thr_wr", 1, 32'h114, 32'hA5, 4'hF, 3'b001, 0, 0, 1);
    n_vec++;
    if (tx_thr_val !== 4'h5 || rx_thr_val !== 4'hA) begin
      n_err++;
      $display("FAIL thr_pins: got tx=%h rx=%h want tx=5 rx=a", tx_thr_val, rx_thr_val);
    end
    tx_level = 4'h3; rx_level = 4'h9; tx_full = 1'b0; rx_empty = 1'b1;
    xfer("status_rd", 0, 32'h118, 0, 4'hF, 3'b001, 32'h0000_00E5, 0, 1);
    rx_empty = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got rdata=%h err=%b waits=%0d, want rdata=%h err=%b waits=%0d",
                 nm, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_block;
    rsp_t e, o;
    string nm;
    int p0, q0;
    xfer("ctrl_block", 1, 32'h108, 32'h9, 4'hF, 3'b001, 0, 0, 1);
    p0 = n_push;
    tx_full = 1'b1;
    // tx_full held through setup and four access cycles, then released
    fork
      xfer("tx_stall", 1, 32'h100, 32'h41, 4'hF, 3'b001, 0, 0, 5);
      begin
        repeat (6) @(negedge pclk);
        tx_full = 1'b0;
      end
    join
    n_vec++;
    if (n_push - p0 !== 1 || last_txd !== 8'h41) begin
      n_err++;
      $display("FAIL tx_stall_push: got pushes=%0d data=%h want pushes=1 data=41",
               n_push - p0, last_txd);
    end
    q0 = n_pop;
    rx_empty = 1'b1;
    // ACCESS cycle plus TIMEOUT stall cycles before the error response
    xfer("rx_timeout", 0, 32'h100, 0, 4'hF, 3'b001, 32'h0, 1, 1 + TIMEOUT);
    xfer("ctrl_noblock", 1, 32'h108, 32'h1, 4'hF, 3'b001, 0, 0, 1);
    xfer("rx_empty_err", 0, 32'h100, 0, 4'hF, 3'b001, 32'h0, 1, 1);
    n_vec++;
    if (n_pop !== q0) begin
      n_err++;
      $display("FAIL rx_no_pop: got pops=%0d want 0", n_pop - q0);
    end
    p0 = n_push;
    tx_full = 1'b1;
    xfer("tx_full_err", 1, 32'h100, 32'h55, 4'hF, 3'b001, 0, 1, 1);
    tx_full = 1'b0;
    rx_empty = 1'b0; rx_data = 8'h5A;
    xfer("rx_read", 0, 32'h100, 0, 4'hF, 3'b001, 32'h5A, 0, 1);
    n_vec++;
    if (n_push !== p0 || n_pop - q0 !== 1) begin
      n_err++;
      $display("FAIL strobe_counts: got pushes=%0d pops=%0d want 0 and 1",
               n_push - p0, n_pop - q0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got rdata=%h err=%b waits=%0d, want rdata=%h err=%b waits=%0d",
                 nm, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_errors;
    rsp_t e, o;
    string nm;
    xfer("misaligned", 0, 32'h102, 0, 4'hF, 3'b001, 32'h0, 1, 1);
    xfer("wr_status",  1, 32'h118, 32'hFF, 4'hF, 3'b001, 0, 1, 1);
    xfer("unpriv_wr",  1, 32'h104, 32'h1234, 4'hF, 3'b000, 0, 1, 1);
    xfer("strb_zero",  1, 32'h104, 32'h4321, 4'h0, 3'b001, 0, 1, 1);
    xfer("base_miss",  0, 32'h204, 0, 4'hF, 3'b001, 32'h0, 1, 1);
    xfer("off_range",  0, 32'h11C, 0, 4'hF, 3'b001, 32'h0, 1, 1);
    xfer("baud_kept",  0, 32'h104, 0, 4'hF, 3'b001, 32'h00CD, 0, 1);
    xfer("thr_kept",   0, 32'h114, 0, 4'hF, 3'b001, 32'h00A5, 0, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got rdata=%h err=%b waits=%0d, want rdata=%h err=%b waits=%0d",
                 nm, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_irq;
    rsp_t e, o;
    string nm;
    @(negedge pclk); int_src = 5'b00100;
    @(negedge pclk); int_src = 5'b00000;
    xfer("stat_set", 0, 32'h110, 0, 4'hF, 3'b001, 32'h04, 0, 1);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_masked: got %b want 0", irq);
    end
    xfer("int_en_wr", 1, 32'h10C, 32'h04, 4'hF, 3'b001, 0, 0, 1);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_lag: got %b want 0", irq);
    end
    @(posedge pclk); #1;
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_rise: got %b want 1", irq);
    end
    // new edge lands in the W1C completion cycle
    fork
      xfer("w1c_vs_edge", 1, 32'h110, 32'h04, 4'hF, 3'b001, 0, 0, 1);
      begin
        for (int i = 0; i < 50 && !pready; i++) @(negedge pclk);
        int_src = 5'b00100;
      end
    join
    xfer("stat_kept", 0, 32'h110, 0, 4'hF, 3'b001, 32'h04, 0, 1);
    int_src = 5'b00000;
    xfer("w1c_clear", 1, 32'h110, 32'h04, 4'hF, 3'b001, 0, 0, 1);
    xfer("stat_clr",  0, 32'h110, 0, 4'hF, 3'b001, 32'h00, 0, 1);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_drop: got %b want 0", irq);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got rdata=%h err=%b waits=%0d, want rdata=%h err=%b waits=%0d",
                 nm, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  task automatic test_reset_stall;
    rsp_t e, o;
    string nm;
    int p0;
    xfer("pre_ctrl", 1, 32'h108, 32'h9, 4'hF, 3'b001, 0, 0, 1);
    xfer("pre_baud", 1, 32'h104, 32'h55, 4'hF, 3'b001, 0, 0, 1);
    tx_full = 1'b1;
    p0 = n_push;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h100;
    pwdata = 32'h33; pstrb = 4'hF; pprot = 3'b001;
    @(negedge pclk); penable = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; tx_full = 1'b0; preset = 1'b0;
    n_vec++;
    if (pready !== 1'b0 || tx_push !== 1'b0 || n_push !== p0) begin
      n_err++;
      $display("FAIL reset_in_stall: got rdy=%b push=%b pushes=%0d want 0 0 0",
               pready, tx_push, n_push - p0);
    end
    n_vec++;
    if (baud_div !== 16'd977 || uart_en !== 1'b0 || tx_thr_val !== 4'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_regs2: got baud=%0d en=%b thr=%h irq=%b want 977 0 0 0",
               baud_div, uart_en, tx_thr_val, irq);
    end
    xfer("post_baud", 0, 32'h104, 0, 4'hF, 3'b001, 32'd977, 0, 1);
    xfer("post_ctrl", 0, 32'h108, 0, 4'hF, 3'b001, 32'd0, 0, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); o = obs_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got rdata=%h err=%b waits=%0d, want rdata=%h err=%b waits=%0d",
                 nm, o.rdata, o.err, o.waits, e.rdata, e.err, e.waits);
      end
    end
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001;
    tx_full = 1'b0; rx_empty = 1'b0; rx_data = '0;
    rx_level = '0; tx_level = '0; int_src = '0;
    repeat (3) @(negedge pclk);
    preset = 1'b0;
    test_reset;
    test_regs;
    test_block;
    test_errors;
    test_irq;
    test_reset_stall;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
